// File: rtl/alu_issue_unit_pkg.sv
// Shared types for the ALU issue unit: opcode encoding, EX-stage payload and default sizes.
package alu_issue_unit_pkg;

  localparam int unsigned DefaultBitwidth     = 16;
  localparam int unsigned DefaultRegCount     = 16;
  localparam int unsigned DefaultRegAddrWidth = $clog2(DefaultRegCount);

  typedef enum logic [3:0] {
    OpAdd    = 4'h0,
    OpInc    = 4'h1,
    OpSub    = 4'h2,
    OpDec    = 4'h3,
    OpAnd    = 4'h4,
    OpXor    = 4'h5,
    OpOr     = 4'h6,
    OpMov    = 4'h7,
    OpCarry  = 4'h8,
    OpBorrow = 4'hA,
    OpNand   = 4'hC,
    OpXnor   = 4'hD,
    OpNor    = 4'hE,
    OpNot    = 4'hF
  } aluOp_e;

  typedef struct packed {
    aluOp_e                         opcode;
    logic [DefaultRegAddrWidth-1:0] dest;
    logic [DefaultBitwidth-1:0]     opA;
    logic [DefaultBitwidth-1:0]     opB;
  } exStage_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port.
module alu_regfile #(
  parameter int unsigned BITWIDTH     = 16,
  parameter int unsigned REGCOUNT     = 16,
  parameter int unsigned REGADDRWIDTH = $clog2(REGCOUNT)
) (
  input  logic                    clk,
  input  logic                    async_nrst,
  input  logic [REGADDRWIDTH-1:0] rdAddrA_i,
  output logic [BITWIDTH-1:0]     rdDataA_o,
  input  logic [REGADDRWIDTH-1:0] rdAddrB_i,
  output logic [BITWIDTH-1:0]     rdDataB_o,
  input  logic                    wrEn_i,
  input  logic [REGADDRWIDTH-1:0] wrAddr_i,
  input  logic [BITWIDTH-1:0]     wrData_i
);

  logic [BITWIDTH-1:0] regs_q [REGCOUNT];

  always_ff @(posedge clk or negedge async_nrst) begin
    if (!async_nrst) begin
      for (int i = 0; i < REGCOUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrEn_i) begin
      regs_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdDataA_o = regs_q[rdAddrA_i];
  assign rdDataB_o = regs_q[rdAddrB_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/EX/WB front end for a combinational ALU: operand read with forwarding, write-back
// into the local register file, and a retired-result valid/ready stream.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int unsigned BITWIDTH     = DefaultBitwidth,
  parameter int unsigned REGCOUNT     = DefaultRegCount,
  parameter int unsigned REGADDRWIDTH = $clog2(REGCOUNT)
) (
  input  logic                    clk,
  input  logic                    async_nrst,
  input  logic                    Instr_Valid,
  output logic                    Instr_Ready,
  input  logic [3:0]              Instr_Opcode,
  input  logic [REGADDRWIDTH-1:0] Instr_Dest,
  input  logic [REGADDRWIDTH-1:0] Instr_SrcA,
  input  logic [REGADDRWIDTH-1:0] Instr_SrcB,
  output logic [BITWIDTH-1:0]     ALU_Data_OutA,
  output logic [BITWIDTH-1:0]     ALU_Data_OutB,
  output logic [3:0]              ALU_Opcode,
  output logic                    ALU_Enable,
  input  logic [BITWIDTH-1:0]     ALU_ResultIn,
  output logic                    Result_Valid,
  input  logic                    Result_Ready,
  output logic [REGADDRWIDTH-1:0] Result_Dest,
  output logic [BITWIDTH-1:0]     Result_Data
);

  exStage_t                exStage_q, exStage_d;
  logic                    exValid_q, exValid_d;
  logic                    wbValid_q, wbValid_d;
  logic [REGADDRWIDTH-1:0] wbDest_q, wbDest_d;
  logic [BITWIDTH-1:0]     wbData_q, wbData_d;

  logic                    advance;
  logic [BITWIDTH-1:0]     rfDataA, rfDataB;
  logic [BITWIDTH-1:0]     opA, opB;

  alu_regfile #(
    .BITWIDTH    (BITWIDTH),
    .REGCOUNT    (REGCOUNT),
    .REGADDRWIDTH(REGADDRWIDTH)
  ) u_regfile (
    .clk       (clk),
    .async_nrst(async_nrst),
    .rdAddrA_i (Instr_SrcA),
    .rdDataA_o (rfDataA),
    .rdAddrB_i (Instr_SrcB),
    .rdDataB_o (rfDataB),
    .wrEn_i    (wbValid_q && Result_Ready),
    .wrAddr_i  (wbDest_q),
    .wrData_i  (wbData_q)
  );

  assign advance     = !wbValid_q || Result_Ready;
  assign Instr_Ready = advance;

  // The youngest in-flight producer wins, so the register file is never read stale.
  always_comb begin
    opA = rfDataA;
    if (exValid_q && exStage_q.dest == Instr_SrcA) begin
      opA = ALU_ResultIn;
    end else if (wbValid_q && wbDest_q == Instr_SrcA) begin
      opA = wbData_q;
    end
  end

  always_comb begin
    opB = rfDataB;
    if (exValid_q && exStage_q.dest == Instr_SrcB) begin
      opB = ALU_ResultIn;
    end else if (wbValid_q && wbDest_q == Instr_SrcB) begin
      opB = wbData_q;
    end
  end

  always_comb begin
    exStage_d = exStage_q;
    exValid_d = exValid_q;
    wbValid_d = wbValid_q;
    wbDest_d  = wbDest_q;
    wbData_d  = wbData_q;
    if (advance) begin
      exValid_d = Instr_Valid;
      if (Instr_Valid) begin
        exStage_d.opcode = aluOp_e'(Instr_Opcode);
        exStage_d.dest   = Instr_Dest;
        exStage_d.opA    = opA;
        exStage_d.opB    = opB;
      end
      wbValid_d = exValid_q;
      if (exValid_q) begin
        wbDest_d = exStage_q.dest;
        wbData_d = ALU_ResultIn;
      end
    end
  end

  always_ff @(posedge clk or negedge async_nrst) begin
    if (!async_nrst) begin
      exStage_q <= '0;
      exValid_q <= 1'b0;
      wbValid_q <= 1'b0;
      wbDest_q  <= '0;
      wbData_q  <= '0;
    end else begin
      exStage_q <= exStage_d;
      exValid_q <= exValid_d;
      wbValid_q <= wbValid_d;
      wbDest_q  <= wbDest_d;
      wbData_q  <= wbData_d;
    end
  end

  assign ALU_Data_OutA = exStage_q.opA;
  assign ALU_Data_OutB = exStage_q.opB;
  assign ALU_Opcode    = exStage_q.opcode;
  assign ALU_Enable    = exValid_q;

  assign Result_Valid = wbValid_q;
  assign Result_Dest  = wbDest_q;
  assign Result_Data  = wbData_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: an ALU model closes the loop; a sequential program-order model
// predicts every operand pair and every retired result.
module tb_alu_issue_unit;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          async_nrst;
  logic          Instr_Valid, Instr_Ready;
  logic [3:0]    Instr_Opcode;
  logic [AW-1:0] Instr_Dest, Instr_SrcA, Instr_SrcB;
  logic [W-1:0]  ALU_Data_OutA, ALU_Data_OutB, ALU_ResultIn;
  logic [3:0]    ALU_Opcode;
  logic          ALU_Enable;
  logic          Result_Valid, Result_Ready;
  logic [AW-1:0] Result_Dest;
  logic [W-1:0]  Result_Data;

  alu_issue_unit dut (
    .clk          (clk),
    .async_nrst   (async_nrst),
    .Instr_Valid  (Instr_Valid),
    .Instr_Ready  (Instr_Ready),
    .Instr_Opcode (Instr_Opcode),
    .Instr_Dest   (Instr_Dest),
    .Instr_SrcA   (Instr_SrcA),
    .Instr_SrcB   (Instr_SrcB),
    .ALU_Data_OutA(ALU_Data_OutA),
    .ALU_Data_OutB(ALU_Data_OutB),
    .ALU_Opcode   (ALU_Opcode),
    .ALU_Enable   (ALU_Enable),
    .ALU_ResultIn (ALU_ResultIn),
    .Result_Valid (Result_Valid),
    .Result_Ready (Result_Ready),
    .Result_Dest  (Result_Dest),
    .Result_Data  (Result_Data)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] aluFn(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'h0: return a + b;
      4'h1: return a + 1'b1;
      4'h2: return a - b;
      4'h3: return a - 1'b1;
      4'h4: return a & b;
      4'h5: return a ^ b;
      4'h6: return a | b;
      4'h7: return b;
      4'h8: return {{(W-1){1'b0}}, s[W]};
      4'hA: return {{(W-1){1'b0}}, (a < b)};
      4'hC: return ~(a & b);
      4'hD: return ~(a ^ b);
      4'hE: return ~(a | b);
      4'hF: return ~a;
      default: return '0;
    endcase
  endfunction

  assign ALU_ResultIn = aluFn(ALU_Opcode, ALU_Data_OutA, ALU_Data_OutB);

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } opExp_t;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [W-1:0]  data;
  } resExp_t;

  logic [W-1:0] refRf [N];
  opExp_t       opQ[$];
  resExp_t      resQ[$];

  int nCompared   = 0;
  int nMismatched = 0;

  // Per-cycle observations taken just before the rising edge.
  logic    tRet, tRetEmpty, tEx, tExEmpty, tAcc, tInstrReady;
  resExp_t tRetObs, tRetExp;
  opExp_t  tExObs, tExExp;

  logic [3:0] opList [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                              4'h8, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};

  task automatic drive(input logic v, input logic [3:0] op, input logic [AW-1:0] d,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
    Instr_Valid  = v;
    Instr_Opcode = op;
    Instr_Dest   = d;
    Instr_SrcA   = a;
    Instr_SrcB   = b;
  endtask

  task automatic clearModel();
    opQ.delete();
    resQ.delete();
    for (int i = 0; i < N; i++) refRf[i] = '0;
  endtask

  // Advance one clock, updating the program-order model from the handshakes seen.
  task automatic tick();
    logic [W-1:0] a, b, r;
    @(negedge clk);
    tInstrReady = Instr_Ready;
    tRet        = Result_Valid && Result_Ready;
    tEx         = ALU_Enable && Instr_Ready;
    tAcc        = Instr_Valid && Instr_Ready;
    tRetObs     = '{Result_Dest, Result_Data};
    tExObs      = '{ALU_Opcode, ALU_Data_OutA, ALU_Data_OutB};
    tRetEmpty   = 1'b0;
    tExEmpty    = 1'b0;
    if (tRet) begin
      if (resQ.size() == 0) tRetEmpty = 1'b1;
      else tRetExp = resQ.pop_front();
    end
    if (tEx) begin
      if (opQ.size() == 0) tExEmpty = 1'b1;
      else tExExp = opQ.pop_front();
    end
    if (tAcc) begin
      a = refRf[Instr_SrcA];
      b = refRf[Instr_SrcB];
      r = aluFn(Instr_Opcode, a, b);
      opQ.push_back('{Instr_Opcode, a, b});
      resQ.push_back('{Instr_Dest, r});
      refRf[Instr_Dest] = r;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] obs [7];
    string        nm  [7];
    obs = '{ALU_Data_OutA, ALU_Data_OutB, W'(ALU_Opcode), W'(ALU_Enable), W'(Result_Valid),
            W'(Result_Dest), Result_Data};
    nm  = '{"alu_a", "alu_b", "alu_op", "alu_en", "res_valid", "res_dest", "res_data"};
    for (int i = 0; i < 7; i++) begin
      nCompared++;
      if (obs[i] !== '0) begin
        nMismatched++;
        $display("FAIL reset_%s: got %h, want 0", nm[i], obs[i]);
      end
    end
    nCompared++;
    if (Instr_Ready !== 1'b1) begin
      nMismatched++;
      $display("FAIL reset_instr_ready: got %b, want 1", Instr_Ready);
    end
  endtask

  task automatic test_mov();
    drive(1'b1, 4'h7, 4'd1, 4'd2, 4'd2);
    tick();
    drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    nCompared++;
    if ({ALU_Enable, ALU_Opcode, ALU_Data_OutB} !== {1'b1, 4'h7, 16'h0000}) begin
      nMismatched++;
      $display("FAIL mov_ex: got en=%b op=%h b=%h, want en=1 op=7 b=0000",
               ALU_Enable, ALU_Opcode, ALU_Data_OutB);
    end
    tick();
    nCompared++;
    if ({Result_Valid, Result_Dest, Result_Data} !== {1'b1, 4'd1, 16'h0000}) begin
      nMismatched++;
      $display("FAIL mov_wb: got v=%b dest=%0d data=%h, want v=1 dest=1 data=0000",
               Result_Valid, Result_Dest, Result_Data);
    end
    tick();
  endtask

  task automatic test_inc_chain();
    Result_Ready = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      if (t <= 5) drive(1'b1, 4'h1, 4'd1, 4'd1, 4'd1);
      else drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
      tick();
      if (t >= 2 && t <= 6) begin
        nCompared++;
        if (!tEx || tExObs.a !== W'(t - 2)) begin
          nMismatched++;
          $display("FAIL inc_fwd t=%0d: got en=%b a=%h, want en=1 a=%h", t, tEx, tExObs.a,
                   W'(t - 2));
        end
      end
      if (t >= 3) begin
        nCompared++;
        if (!tRet || tRetObs !== {4'd1, W'(t - 2)}) begin
          nMismatched++;
          $display("FAIL inc_result t=%0d: got v=%b dest=%0d data=%h, want v=1 dest=1 data=%h",
                   t, tRet, tRetObs.dest, tRetObs.data, W'(t - 2));
        end
      end
    end
  endtask

  task automatic test_sub_xor();
    for (int t = 1; t <= 8; t++) begin
      if (t <= 3) drive(1'b1, 4'h1, 4'd2, 4'd2, 4'd2);
      else if (t == 4) drive(1'b1, 4'h2, 4'd3, 4'd1, 4'd2);
      else if (t == 5) drive(1'b1, 4'h5, 4'd4, 4'd3, 4'd1);
      else drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
      tick();
      if (t == 5 || t == 6) begin
        nCompared++;
        if (!tEx || {tExObs.a, tExObs.b} !== ((t == 5) ? {16'd5, 16'd3} : {16'd2, 16'd5})) begin
          nMismatched++;
          $display("FAIL subxor_operands t=%0d: got en=%b a=%h b=%h", t, tEx, tExObs.a,
                   tExObs.b);
        end
      end
      if (t == 6 || t == 7) begin
        nCompared++;
        if (!tRet || tRetObs !== ((t == 6) ? {4'd3, 16'd2} : {4'd4, 16'd7})) begin
          nMismatched++;
          $display("FAIL subxor_result t=%0d: got v=%b dest=%0d data=%h", t, tRet,
                   tRetObs.dest, tRetObs.data);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [2*W+4+1+1+AW+W-1:0] snap;
    int                        nRet;
    Result_Ready = 1'b0;
    drive(1'b1, 4'h0, 4'd8, 4'd1, 4'd2);
    tick();
    drive(1'b1, 4'h2, 4'd9, 4'd8, 4'd2);
    tick();
    drive(1'b1, 4'h6, 4'd10, 4'd9, 4'd1);
    snap = {ALU_Data_OutA, ALU_Data_OutB, ALU_Opcode, ALU_Enable, Result_Valid, Result_Dest,
            Result_Data};
    for (int c = 0; c < 3; c++) begin
      tick();
      nCompared++;
      if (tInstrReady !== 1'b0) begin
        nMismatched++;
        $display("FAIL stall_ready c=%0d: got %b, want 0", c, tInstrReady);
      end
      nCompared++;
      if ({ALU_Data_OutA, ALU_Data_OutB, ALU_Opcode, ALU_Enable, Result_Valid, Result_Dest,
           Result_Data} !== snap) begin
        nMismatched++;
        $display("FAIL stall_hold c=%0d: got a=%h b=%h rv=%b rd=%h, want %h", c, ALU_Data_OutA,
                 ALU_Data_OutB, Result_Valid, Result_Data, snap);
      end
    end
    Result_Ready = 1'b1;
    nRet = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (tAcc) drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
      if (tRet) begin
        nRet++;
        nCompared++;
        if (tRetEmpty || tRetObs !== tRetExp) begin
          nMismatched++;
          $display("FAIL stall_drain: got dest=%0d data=%h, want dest=%0d data=%h",
                   tRetObs.dest, tRetObs.data, tRetExp.dest, tRetExp.data);
        end
      end
    end
    nCompared++;
    if (nRet != 3 || resQ.size() != 0) begin
      nMismatched++;
      $display("FAIL stall_count: got %0d retired (%0d pending), want 3 (0)", nRet,
               resQ.size());
    end
  endtask

  task automatic test_carry();
    for (int t = 1; t <= 6; t++) begin
      if (t == 1) drive(1'b1, 4'h3, 4'd5, 4'd5, 4'd5);
      else if (t == 2) drive(1'b1, 4'h1, 4'd6, 4'd6, 4'd6);
      else if (t == 3) drive(1'b1, 4'h8, 4'd7, 4'd5, 4'd6);
      else drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
      tick();
      if (t == 4) begin
        nCompared++;
        if (!tEx || tExObs !== {4'h8, 16'hFFFF, 16'h0001}) begin
          nMismatched++;
          $display("FAIL carry_operands: got en=%b op=%h a=%h b=%h, want op=8 a=ffff b=0001",
                   tEx, tExObs.op, tExObs.a, tExObs.b);
        end
      end
      if (t == 5) begin
        nCompared++;
        if (!tRet || tRetObs !== {4'd7, 16'h0001}) begin
          nMismatched++;
          $display("FAIL carry_result: got v=%b dest=%0d data=%h, want dest=7 data=0001",
                   tRet, tRetObs.dest, tRetObs.data);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!Instr_Valid || tAcc) begin
        drive(($urandom_range(0, 3) != 0), opList[$urandom_range(0, 13)],
              AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3)),
              AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3)),
              AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3)));
      end
      Result_Ready = (c >= 395) || ($urandom_range(0, 3) != 0);
      if (c >= 395) Instr_Valid = 1'b0;
      tick();
      if (tEx) begin
        nCompared++;
        if (tExEmpty || tExObs !== tExExp) begin
          nMismatched++;
          $display("FAIL rand_operands c=%0d: got op=%h a=%h b=%h, want op=%h a=%h b=%h", c,
                   tExObs.op, tExObs.a, tExObs.b, tExExp.op, tExExp.a, tExExp.b);
        end
      end
      if (tRet) begin
        nCompared++;
        if (tRetEmpty || tRetObs !== tRetExp) begin
          nMismatched++;
          $display("FAIL rand_result c=%0d: got dest=%0d data=%h, want dest=%0d data=%h", c,
                   tRetObs.dest, tRetObs.data, tRetExp.dest, tRetExp.data);
        end
      end
    end
    nCompared++;
    if (resQ.size() != 0 || opQ.size() != 0) begin
      nMismatched++;
      $display("FAIL rand_drain: got %0d results and %0d operand sets pending, want 0",
               resQ.size(), opQ.size());
    end
  endtask

  task automatic test_reset_midflight();
    int nRet;
    Result_Ready = 1'b0;
    drive(1'b1, 4'h0, 4'd1, 4'd1, 4'd1);
    tick();
    drive(1'b1, 4'h1, 4'd2, 4'd2, 4'd2);
    tick();
    drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    #2;
    async_nrst = 1'b0;
    #1;
    nCompared++;
    if ({Result_Valid, ALU_Enable, Result_Data, ALU_Data_OutA} !== '0) begin
      nMismatched++;
      $display("FAIL midreset_clear: got rv=%b en=%b rdata=%h a=%h, want all 0", Result_Valid,
               ALU_Enable, Result_Data, ALU_Data_OutA);
    end
    clearModel();
    @(negedge clk);
    async_nrst = 1'b1;
    @(posedge clk);
    #1;
    Result_Ready = 1'b1;
    nRet = 0;
    for (int t = 0; t < N + 3; t++) begin
      if (t < N) drive(1'b1, 4'h7, AW'(t), AW'(t), AW'(t));
      else drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
      tick();
      if (tEx) begin
        nCompared++;
        if ({tExObs.a, tExObs.b} !== '0) begin
          nMismatched++;
          $display("FAIL midreset_read t=%0d: got a=%h b=%h, want 0000", t, tExObs.a, tExObs.b);
        end
      end
      if (tRet) nRet++;
    end
    nCompared++;
    if (nRet != N) begin
      nMismatched++;
      $display("FAIL midreset_count: got %0d retired, want %0d", nRet, N);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    async_nrst   = 1'b0;
    Result_Ready = 1'b1;
    tAcc         = 1'b0;
    drive(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    clearModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_nrst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_mov();
    test_inc_chain();
    test_sub_xor();
    test_stall();
    test_carry();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
